// File: rtl/command_scheduler.sv
// -----------------------------------------------------------------------------
// command_scheduler
//   Picks one of the read/write pool heads using the priorities supplied by
//   timing_control, then sequences PRE/ACT/RD/WR to the DRAM while tracking the
//   open row of each bank and honouring tRP, tRCD, tCCD and tWTR. The winning
//   pool is popped in the access cycle, and the issued/last_* signals feed
//   back into timing_control.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   read_valid/write_valid   pool non-empty flags
//   read_row/read_bank       read pool head
//   write_row/write_bank     write pool head
//   read_priority/
//   write_priority           priority_t class (lower value wins)
//   write_urgent             write pool near full, breaks ties toward WRITE
//   cmd/cmd_row/cmd_bank     DRAM command (0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR)
//   read_pop/write_pop       one-cycle pool pops, only in the access cycle
//   read_issued/write_issued one-cycle pulses alongside RD/WR
//   last_row/last_bank       target of the most recent RD/WR
// -----------------------------------------------------------------------------
module command_scheduler #(
    parameter int T_RP  = 3,
    parameter int T_RCD = 3,
    parameter int T_CCD = 2,
    parameter int T_WTR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_valid,
    input  logic       write_valid,
    input  logic [2:0] read_row,
    input  logic [1:0] read_bank,
    input  logic [2:0] write_row,
    input  logic [1:0] write_bank,
    input  logic [1:0] read_priority,
    input  logic [1:0] write_priority,
    input  logic       write_urgent,
    output logic [2:0] cmd,
    output logic [2:0] cmd_row,
    output logic [1:0] cmd_bank,
    output logic       read_pop,
    output logic       write_pop,
    output logic       read_issued,
    output logic       write_issued,
    output logic [2:0] last_row,
    output logic [1:0] last_bank
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ACCESS, S_GAP
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_PRE = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    // Wait counters hold the number of extra wait cycles still to run after
    // the current one, so a wait of N cycles loads N-1.
    localparam logic [7:0] RP_LD  = (T_RP  > 1) ? 8'(T_RP  - 2) : 8'd0;
    localparam logic [7:0] RCD_LD = (T_RCD > 1) ? 8'(T_RCD - 2) : 8'd0;
    localparam logic [7:0] CCD_LD = (T_CCD > 1) ? 8'(T_CCD - 2) : 8'd0;
    localparam logic [7:0] WTR_LD = (T_WTR > 1) ? 8'(T_WTR - 1) : 8'd0;

    state_t          state_q, state_d;
    logic [7:0]      wait_q, wait_d;
    logic [7:0]      wtr_q, wtr_d;
    logic            dir_q, dir_d;          // 1 = WRITE
    logic [2:0]      row_q, row_d;
    logic [1:0]      bank_q, bank_d;
    logic [3:0]      open_valid_q, open_valid_d;
    logic [3:0][2:0] open_row_q, open_row_d;
    logic            last_dir_q, last_dir_d;
    logic [2:0]      last_row_q, last_row_d;
    logic [1:0]      last_bank_q, last_bank_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [2:0]      cmd_row_q, cmd_row_d;
    logic [1:0]      cmd_bank_q, cmd_bank_d;
    logic            rd_pop_q, rd_pop_d;
    logic            wr_pop_q, wr_pop_d;
    logic            pick_wr;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        dir_d        = dir_q;
        row_d        = row_q;
        bank_d       = bank_q;
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        last_dir_d   = last_dir_q;
        last_row_d   = last_row_q;
        last_bank_d  = last_bank_q;
        cmd_d        = CMD_NOP;
        cmd_row_d    = 3'd0;
        cmd_bank_d   = 2'd0;
        rd_pop_d     = 1'b0;
        wr_pop_d     = 1'b0;

        // Direction arbitration: lower priority class wins; ties go to an
        // urgent write pool, otherwise stick with the previous direction.
        if (read_valid && write_valid) begin
            if (read_priority < write_priority)      pick_wr = 1'b0;
            else if (read_priority > write_priority) pick_wr = 1'b1;
            else                                     pick_wr = write_urgent | last_dir_q;
        end else begin
            pick_wr = write_valid;
        end

        case (state_q)
            S_IDLE: begin
                // A READ blocked by tWTR holds in IDLE; it does not fall back
                // to the write pool.
                if ((read_valid || write_valid) && (pick_wr || wtr_q == 8'd0)) begin
                    dir_d  = pick_wr;
                    row_d  = pick_wr ? write_row  : read_row;
                    bank_d = pick_wr ? write_bank : read_bank;
                    if (open_valid_q[bank_d] && open_row_q[bank_d] == row_d)
                        state_d = S_ACCESS;
                    else if (open_valid_q[bank_d])
                        state_d = S_PRE;
                    else
                        state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (T_RP == 1) state_d = S_ACT;
                else begin
                    state_d = S_WAIT_RP;
                    wait_d  = RP_LD;
                end
            end
            S_WAIT_RP: begin
                if (wait_q == 8'd0) state_d = S_ACT;
                else                wait_d  = wait_q - 8'd1;
            end
            S_ACT: begin
                if (T_RCD == 1) state_d = S_ACCESS;
                else begin
                    state_d = S_WAIT_RCD;
                    wait_d  = RCD_LD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_q == 8'd0) state_d = S_ACCESS;
                else                wait_d  = wait_q - 8'd1;
            end
            S_ACCESS: begin
                if (T_CCD == 1) state_d = S_IDLE;
                else begin
                    state_d = S_GAP;
                    wait_d  = CCD_LD;
                end
            end
            S_GAP: begin
                if (wait_q == 8'd0) state_d = S_IDLE;
                else                wait_d  = wait_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered, so the command
        // appears in the same cycle the FSM sits in that state.
        case (state_d)
            S_PRE: begin
                cmd_d      = CMD_PRE;
                cmd_bank_d = bank_d;
            end
            S_ACT: begin
                cmd_d      = CMD_ACT;
                cmd_row_d  = row_d;
                cmd_bank_d = bank_d;
            end
            S_ACCESS: begin
                cmd_d      = dir_d ? CMD_WR : CMD_RD;
                cmd_row_d  = row_d;
                cmd_bank_d = bank_d;
                rd_pop_d   = ~dir_d;
                wr_pop_d   = dir_d;
            end
            default: ;
        endcase

        // Bank table follows the PRE/ACT actually issued this cycle.
        if (state_q == S_PRE) open_valid_d[bank_q] = 1'b0;
        if (state_q == S_ACT) begin
            open_valid_d[bank_q] = 1'b1;
            open_row_d[bank_q]   = row_q;
        end

        if (state_q == S_ACCESS) begin
            last_dir_d  = dir_q;
            last_row_d  = row_q;
            last_bank_d = bank_q;
        end

        // tWTR counter runs every cycle; a WR reloads it.
        wtr_d = (wtr_q != 8'd0) ? wtr_q - 8'd1 : 8'd0;
        if (state_q == S_ACCESS && dir_q) wtr_d = WTR_LD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_q       <= 8'd0;
            wtr_q        <= 8'd0;
            dir_q        <= 1'b0;
            row_q        <= 3'd0;
            bank_q       <= 2'd0;
            open_valid_q <= '0;
            open_row_q   <= '0;
            last_dir_q   <= 1'b0;
            last_row_q   <= 3'd0;
            last_bank_q  <= 2'd0;
            cmd_q        <= CMD_NOP;
            cmd_row_q    <= 3'd0;
            cmd_bank_q   <= 2'd0;
            rd_pop_q     <= 1'b0;
            wr_pop_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            wtr_q        <= wtr_d;
            dir_q        <= dir_d;
            row_q        <= row_d;
            bank_q       <= bank_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
            last_dir_q   <= last_dir_d;
            last_row_q   <= last_row_d;
            last_bank_q  <= last_bank_d;
            cmd_q        <= cmd_d;
            cmd_row_q    <= cmd_row_d;
            cmd_bank_q   <= cmd_bank_d;
            rd_pop_q     <= rd_pop_d;
            wr_pop_q     <= wr_pop_d;
        end
    end

    assign cmd          = cmd_q;
    assign cmd_row      = cmd_row_q;
    assign cmd_bank     = cmd_bank_q;
    assign read_pop     = rd_pop_q;
    assign write_pop    = wr_pop_q;
    assign read_issued  = rd_pop_q;
    assign write_issued = wr_pop_q;
    assign last_row     = last_row_q;
    assign last_bank    = last_bank_q;

endmodule

// File: tb/tb_command_scheduler.sv
// -----------------------------------------------------------------------------
// tb_command_scheduler
//   Random pool traffic, priorities and resets against a transaction-level
//   reference: each selection is turned into a list of timestamped DRAM
//   commands derived from the timing parameters, and every cycle the DUT
//   outputs are compared with that list.
// -----------------------------------------------------------------------------
module tb_command_scheduler;
    localparam int T_RP  = 3;
    localparam int T_RCD = 3;
    localparam int T_CCD = 2;
    localparam int T_WTR = 4;
    localparam int NCYC  = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       read_valid, write_valid;
    logic [2:0] read_row, write_row;
    logic [1:0] read_bank, write_bank;
    logic [1:0] read_priority, write_priority;
    logic       write_urgent;
    logic [2:0] cmd, cmd_row, last_row;
    logic [1:0] cmd_bank, last_bank;
    logic       read_pop, write_pop, read_issued, write_issued;

    always #5 clk = ~clk;

    command_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CCD(T_CCD), .T_WTR(T_WTR)) dut (
        .clk(clk), .rst(rst),
        .read_valid(read_valid), .write_valid(write_valid),
        .read_row(read_row), .read_bank(read_bank),
        .write_row(write_row), .write_bank(write_bank),
        .read_priority(read_priority), .write_priority(write_priority),
        .write_urgent(write_urgent),
        .cmd(cmd), .cmd_row(cmd_row), .cmd_bank(cmd_bank),
        .read_pop(read_pop), .write_pop(write_pop),
        .read_issued(read_issued), .write_issued(write_issued),
        .last_row(last_row), .last_bank(last_bank)
    );

    typedef struct { int cyc; int cmd; int row; int bank; } exp_t;
    typedef struct { int row; int bank; } req_t;

    req_t rq[$];
    req_t wq[$];
    exp_t sched[$];

    int n_chk = 0, n_pass = 0;
    int cyc;
    bit m_open[4];
    int m_orow[4];
    int m_last_dir, m_last_wr, m_last_row, m_last_bank;
    int next_idle, rcd_lo, rcd_hi;
    int n_rd = 0, n_wr = 0, n_forced = 0;
    bit rst_drv;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    endtask

    task automatic model_reset();
        sched.delete();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
            m_orow[b] = 0;
        end
        m_last_dir  = 0;
        m_last_wr   = -1000;
        m_last_row  = 0;
        m_last_bank = 0;
        next_idle   = cyc;
        rcd_lo      = -1;
        rcd_hi      = -1;
    endtask

    task automatic push_cmd(input int c, input int op, input int row, input int bank);
        exp_t e;
        e.cyc = c; e.cmd = op; e.row = row; e.bank = bank;
        sched.push_back(e);
    endtask

    // One arbitration decision on the inputs currently driven; schedules the
    // resulting command sequence starting next cycle.
    task automatic decide();
        bit rv, wv, pw;
        req_t h;
        int base, acc;
        rv = rq.size() > 0;
        wv = wq.size() > 0;
        if (!rv && !wv) return;
        if (rv && wv) begin
            if (read_priority < write_priority)      pw = 1'b0;
            else if (read_priority > write_priority) pw = 1'b1;
            else                                     pw = write_urgent || (m_last_dir == 1);
        end else begin
            pw = wv;
        end
        if (!pw && (cyc - m_last_wr) < T_WTR) return;
        h = pw ? wq[0] : rq[0];
        base = cyc + 1;
        rcd_lo = -1;
        rcd_hi = -1;
        if (m_open[h.bank] && m_orow[h.bank] == h.row) begin
            acc = base;
        end else begin
            if (m_open[h.bank]) begin
                push_cmd(base, 2, 0, h.bank);
                base += T_RP;
            end
            push_cmd(base, 1, h.row, h.bank);
            acc    = base + T_RCD;
            rcd_lo = base;
            rcd_hi = acc;
        end
        push_cmd(acc, pw ? 4 : 3, h.row, h.bank);
        next_idle      = acc + T_CCD;
        m_open[h.bank] = 1'b1;
        m_orow[h.bank] = h.row;
        m_last_dir     = pw ? 1 : 0;
        if (pw) m_last_wr = acc;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.row  = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(0, 7));
        r.bank = int'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        exp_t e;
        req_t r;
        rst = 1'b1; rst_drv = 1'b1;
        read_valid = 1'b0; write_valid = 1'b0;
        read_row = '0; read_bank = '0; write_row = '0; write_bank = '0;
        read_priority = '0; write_priority = '0; write_urgent = 1'b0;
        cyc = -1;
        model_reset();
        // Opening traffic: first access, a row hit, then a row conflict on bank 1.
        r.row = 3; r.bank = 1; rq.push_back(r); rq.push_back(r);
        r.row = 5; rq.push_back(r);

        repeat (NCYC) begin
            @(posedge clk); #1;
            cyc++;
            if (rst_drv) model_reset();

            if (sched.size() > 0 && sched[0].cyc == cyc) e = sched.pop_front();
            else begin
                e.cyc = cyc; e.cmd = 0; e.row = 0; e.bank = 0;
            end
            chk("cmd", int'(cmd), e.cmd);
            if (e.cmd != 0) chk("cmd_bank", int'(cmd_bank), e.bank);
            if (e.cmd == 1 || e.cmd == 3 || e.cmd == 4) chk("cmd_row", int'(cmd_row), e.row);
            chk("read_pop", int'(read_pop), (e.cmd == 3) ? 1 : 0);
            chk("write_pop", int'(write_pop), (e.cmd == 4) ? 1 : 0);
            chk("read_issued", int'(read_issued), (e.cmd == 3) ? 1 : 0);
            chk("write_issued", int'(write_issued), (e.cmd == 4) ? 1 : 0);
            chk("last_row", int'(last_row), m_last_row);
            chk("last_bank", int'(last_bank), m_last_bank);
            if (read_issued) n_rd++;
            if (write_issued) n_wr++;
            if (e.cmd == 3 || e.cmd == 4) begin
                m_last_row  = e.row;
                m_last_bank = e.bank;
                if (e.cmd == 3) void'(rq.pop_front());
                else            void'(wq.pop_front());
            end

            // Reset: initial hold, deliberate hits inside the tRCD wait, and rare random ones.
            rst_drv = 1'b0;
            if (cyc < 2) rst_drv = 1'b1;
            else if (cyc > 40 && n_forced < 4 && cyc > rcd_lo && cyc < rcd_hi
                     && $urandom_range(0, 3) == 0) begin
                rst_drv = 1'b1;
                n_forced++;
            end else if (cyc > 40 && $urandom_range(0, 299) == 0) rst_drv = 1'b1;
            rst = rst_drv;

            if (cyc >= 40) begin
                if (rq.size() < 4 && $urandom_range(0, 3) == 0) rq.push_back(rand_req());
                if (wq.size() < 4 && $urandom_range(0, 3) == 0) wq.push_back(rand_req());
            end
            read_valid  = rq.size() > 0;
            write_valid = wq.size() > 0;
            read_row    = (rq.size() > 0) ? 3'(rq[0].row)  : 3'd0;
            read_bank   = (rq.size() > 0) ? 2'(rq[0].bank) : 2'd0;
            write_row   = (wq.size() > 0) ? 3'(wq[0].row)  : 3'd0;
            write_bank  = (wq.size() > 0) ? 2'(wq[0].bank) : 2'd0;
            if (cyc < 40) begin
                read_priority  = 2'd2;
                write_priority = 2'd3;
                write_urgent   = 1'b0;
            end else begin
                read_priority  = 2'($urandom_range(0, 3));
                write_priority = ($urandom_range(0, 2) == 0) ? read_priority
                                                             : 2'($urandom_range(0, 3));
                write_urgent   = ($urandom_range(0, 3) == 0);
            end

            if (!rst_drv && cyc >= next_idle) decide();
        end

        chk("rd_activity", (n_rd > 0) ? 1 : 0, 1);
        chk("wr_activity", (n_wr > 0) ? 1 : 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
